alu_exec_unit: RTL and testbench

// - Execute-stage datapath: ALU-control decode, 64-bit ALU with zero flag, and
//   the two PC adders (sequential PC+4, branch target PC + (imm<<2)).
// - Sits between register-bank/immediate mux and data-memory/PC-select mux.
// - All outputs registered: one-cycle latency, qualified by out_valid.

---
 rtl/alu_exec_unit_if.sv | 32 +++
 rtl/alu_exec_unit.sv | 136 +++++++++++++
 tb/tb_alu_exec_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Bundles the execute-stage operand inputs and the registered result outputs.
// slave: the execute unit. master: whoever drives operands and consumes results.
interface alu_exec_unit_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic [1:0]       alu_op;
    logic [10:0]      opcode;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] imm_ext;

    logic             out_valid;
    logic [3:0]       alu_ctl;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] branch_target;

    modport master (
        output in_valid, alu_op, opcode, operand_a, operand_b, pc, imm_ext,
        input  out_valid, alu_ctl, result, zero, carry, overflow, pc_plus4, branch_target
    );

    modport slave (
        input  in_valid, alu_op, opcode, operand_a, operand_b, pc, imm_ext,
        output out_valid, alu_ctl, result, zero, carry, overflow, pc_plus4, branch_target
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU-control decode, ALU with zero/carry/overflow flags and the
// two PC adders. Every output is registered; data outputs hold when in_valid is low.
module alu_exec_unit #(
    parameter int WIDTH   = 64,
    parameter int PC_STEP = 4
) (
    input  logic           clk,
    input  logic           reset,
    alu_exec_unit_if.slave io
);
    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_ORR  = 4'b0001;
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_PASS = 4'b0111;
    localparam logic [3:0] CTL_NOR  = 4'b1100;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

    logic             out_valid_q, out_valid_d;
    logic [3:0]       alu_ctl_q, alu_ctl_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] pc_plus4_q, pc_plus4_d;
    logic [WIDTH-1:0] branch_target_q, branch_target_d;

    logic [3:0]       ctl_c;
    logic [WIDTH-1:0] res_c;
    logic             carry_c;
    logic             ovf_c;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic             a_msb, b_msb;

    always_comb begin
        ctl_c = CTL_ADD;
        case (io.alu_op)
            2'b01:   ctl_c = CTL_PASS;
            2'b10: begin
                case (io.opcode)
                    OPC_ADD: ctl_c = CTL_ADD;
                    OPC_SUB: ctl_c = CTL_SUB;
                    OPC_AND: ctl_c = CTL_AND;
                    OPC_ORR: ctl_c = CTL_ORR;
                    default: ctl_c = CTL_ADD;
                endcase
            end
            default: ctl_c = CTL_ADD;
        endcase
    end

    // Subtract as a + ~b + 1 so carry-out reads as "no borrow".
    assign add_sum = {1'b0, io.operand_a} + {1'b0, io.operand_b};
    assign sub_sum = {1'b0, io.operand_a} + {1'b0, ~io.operand_b} + {{WIDTH{1'b0}}, 1'b1};
    assign a_msb   = io.operand_a[WIDTH-1];
    assign b_msb   = io.operand_b[WIDTH-1];

    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (ctl_c)
            CTL_AND:  res_c = io.operand_a & io.operand_b;
            CTL_ORR:  res_c = io.operand_a | io.operand_b;
            CTL_ADD: begin
                res_c   = add_sum[WIDTH-1:0];
                carry_c = add_sum[WIDTH];
                ovf_c   = (a_msb == b_msb) && (add_sum[WIDTH-1] != a_msb);
            end
            CTL_SUB: begin
                res_c   = sub_sum[WIDTH-1:0];
                carry_c = sub_sum[WIDTH];
                ovf_c   = (a_msb != b_msb) && (sub_sum[WIDTH-1] != a_msb);
            end
            CTL_PASS: res_c = io.operand_b;
            CTL_NOR:  res_c = ~(io.operand_a | io.operand_b);
            default:  res_c = '0;
        endcase
    end

    always_comb begin
        out_valid_d     = io.in_valid;
        alu_ctl_d       = alu_ctl_q;
        result_d        = result_q;
        zero_d          = zero_q;
        carry_d         = carry_q;
        overflow_d      = overflow_q;
        pc_plus4_d      = pc_plus4_q;
        branch_target_d = branch_target_q;
        if (io.in_valid) begin
            alu_ctl_d       = ctl_c;
            result_d        = res_c;
            zero_d          = (res_c == '0);
            carry_d         = carry_c;
            overflow_d      = ovf_c;
            pc_plus4_d      = io.pc + WIDTH'(PC_STEP);
            branch_target_d = io.pc + (io.imm_ext << 2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q     <= 1'b0;
            alu_ctl_q       <= '0;
            result_q        <= '0;
            zero_q          <= 1'b0;
            carry_q         <= 1'b0;
            overflow_q      <= 1'b0;
            pc_plus4_q      <= '0;
            branch_target_q <= '0;
        end else begin
            out_valid_q     <= out_valid_d;
            alu_ctl_q       <= alu_ctl_d;
            result_q        <= result_d;
            zero_q          <= zero_d;
            carry_q         <= carry_d;
            overflow_q      <= overflow_d;
            pc_plus4_q      <= pc_plus4_d;
            branch_target_q <= branch_target_d;
        end
    end

    assign io.out_valid     = out_valid_q;
    assign io.alu_ctl       = alu_ctl_q;
    assign io.result        = result_q;
    assign io.zero          = zero_q;
    assign io.carry         = carry_q;
    assign io.overflow      = overflow_q;
    assign io.pc_plus4      = pc_plus4_q;
    assign io.branch_target = branch_target_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed corner cases plus random operands, checked
// against an arithmetic reference model of the execute stage.
module tb_alu_exec_unit;
    localparam logic signed [127:0] SMAX = (128'sd1 <<< 63) - 128'sd1;
    localparam logic signed [127:0] SMIN = -(128'sd1 <<< 63);

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_exec_unit_if #(.WIDTH(64)) bus ();
    alu_exec_unit #(.WIDTH(64), .PC_STEP(4)) dut (.clk(clk), .reset(reset), .io(bus));

    always #5 clk = ~clk;

    logic        e_valid, e_zero, e_carry, e_ovf;
    logic [3:0]  e_ctl;
    logic [63:0] e_res, e_p4, e_bt;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_ctl(input logic [1:0] op, input logic [10:0] opc);
        if (op == 2'b01) return 4'b0111;
        if (op != 2'b10) return 4'b0010;
        case (opc)
            11'b11001011000: return 4'b0110;
            11'b10001010000: return 4'b0000;
            11'b10101010000: return 4'b0001;
            default:         return 4'b0010;
        endcase
    endfunction

    // Reference: wide signed arithmetic decides overflow; unsigned compare decides borrow.
    task automatic ref_alu(input logic [3:0] ctl, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] r, output logic c, output logic v);
        logic signed [127:0] sa, sb, wide;
        logic [64:0] full;
        sa = $signed(a);
        sb = $signed(b);
        r = 64'd0; c = 1'b0; v = 1'b0;
        case (ctl)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0111: r = b;
            4'b0010: begin
                full = {1'b0, a} + {1'b0, b};
                r = full[63:0];
                c = full[64];
                wide = sa + sb;
                v = (wide > SMAX) || (wide < SMIN);
            end
            4'b0110: begin
                r = a - b;
                c = (a >= b);
                wide = sa - sb;
                v = (wide > SMAX) || (wide < SMIN);
            end
            default: r = 64'd0;
        endcase
    endtask

    task automatic model_update();
        logic [63:0] r;
        logic c, v;
        if (reset) begin
            e_valid = 0; e_ctl = 0; e_res = 0; e_zero = 0; e_carry = 0; e_ovf = 0; e_p4 = 0; e_bt = 0;
        end else begin
            e_valid = bus.in_valid;
            if (bus.in_valid) begin
                e_ctl = ref_ctl(bus.alu_op, bus.opcode);
                ref_alu(e_ctl, bus.operand_a, bus.operand_b, r, c, v);
                e_res = r; e_carry = c; e_ovf = v;
                e_zero = (r == 64'd0);
                e_p4 = bus.pc + 64'd4;
                e_bt = bus.pc + bus.imm_ext * 64'd4;
            end
        end
    endtask

    task automatic step(input logic rst, input logic vld, input logic [1:0] op, input logic [10:0] opc,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] p, input logic [63:0] imm);
        reset = rst; bus.in_valid = vld; bus.alu_op = op; bus.opcode = opc;
        bus.operand_a = a; bus.operand_b = b; bus.pc = p; bus.imm_ext = imm;
        @(posedge clk);
        model_update();
        #1;
        check_eq("out_valid", 64'(bus.out_valid), 64'(e_valid));
        check_eq("alu_ctl", 64'(bus.alu_ctl), 64'(e_ctl));
        check_eq("result", bus.result, e_res);
        check_eq("zero", 64'(bus.zero), 64'(e_zero));
        check_eq("carry", 64'(bus.carry), 64'(e_carry));
        check_eq("overflow", 64'(bus.overflow), 64'(e_ovf));
        check_eq("pc_plus4", bus.pc_plus4, e_p4);
        check_eq("branch_target", bus.branch_target, e_bt);
    endtask

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;

    initial begin
        logic [10:0] opcs [4];
        opcs[0] = OP_ADD; opcs[1] = OP_SUB; opcs[2] = OP_AND; opcs[3] = OP_ORR;

        // Reset wins over in_valid with nonzero inputs.
        step(1, 1, 2'b10, OP_SUB, 64'd7, 64'd3, 64'h100, 64'd5);
        check_eq("rst_result_zero", bus.result, 64'd0);
        check_eq("rst_valid_zero", 64'(bus.out_valid), 64'd0);

        step(0, 1, 2'b10, OP_SUB, 64'd10, 64'd10, 64'h0, 64'h0);
        check_eq("sub_ctl", 64'(bus.alu_ctl), 64'b0110);
        check_eq("sub_zero", 64'(bus.zero), 64'd1);
        check_eq("sub_carry", 64'(bus.carry), 64'd1);

        step(0, 1, 2'b10, OP_ORR, 64'hF0, 64'h0F, 64'h0, 64'h0);
        check_eq("orr_result", bus.result, 64'hFF);
        step(0, 1, 2'b10, OP_AND, 64'hF0, 64'h0F, 64'h0, 64'h0);
        check_eq("and_zero", 64'(bus.zero), 64'd1);

        step(0, 1, 2'b01, 11'h0, 64'd99, 64'd0, 64'h0, 64'h0);
        check_eq("cbz_ctl", 64'(bus.alu_ctl), 64'b0111);
        check_eq("cbz_zero", 64'(bus.zero), 64'd1);
        step(0, 1, 2'b01, 11'h0, 64'd0, 64'd5, 64'h0, 64'h0);
        check_eq("cbz_nonzero", 64'(bus.zero), 64'd0);

        step(0, 1, 2'b00, 11'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 64'h0);
        check_eq("wrap_carry", 64'(bus.carry), 64'd1);
        check_eq("wrap_ovf", 64'(bus.overflow), 64'd0);
        step(0, 1, 2'b00, 11'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 64'h0);
        check_eq("signed_ovf", 64'(bus.overflow), 64'd1);

        step(0, 1, 2'b11, 11'h0, 64'd1, 64'd2, 64'h100, -64'sd2);
        check_eq("pc_plus4_c", bus.pc_plus4, 64'h104);
        check_eq("branch_back", bus.branch_target, 64'hF8);
        step(0, 0, 2'b10, OP_AND, 64'd5, 64'd6, 64'h500, 64'd9);
        check_eq("hold_target", bus.branch_target, 64'hF8);

        for (int i = 0; i < 400; i++) begin
            logic [1:0]  op;
            logic [10:0] opc;
            logic [63:0] a, b;
            op  = 2'($urandom_range(0, 3));
            opc = ($urandom_range(0, 4) == 0) ? 11'($urandom) : opcs[$urandom_range(0, 3)];
            a = {$urandom, $urandom};
            b = ($urandom_range(0, 5) == 0) ? a : {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) b = 64'd0;
            step(($urandom_range(0, 40) == 0), ($urandom_range(0, 4) != 0), op, opc, a, b,
                 {$urandom, $urandom}, {$urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
